// File: rtl/king_move_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : king_move_scheduler
// Purpose  : Generates the pseudo-legal king moves for the side to move.
//            The block scans the board for the king, launches one king-move
//            generator on the king's square, and collects the 8 candidate
//            targets. It filters the candidates against board occupancy and
//            drains the surviving moves over a valid/ready handshake.
// Ports    : clk, rst_n                - clock, async active-low reset
//            start_i, side_i            - run request and colour to move
//            bd_addr_o, bd_piece_i      - combinational board read port
//            gen_start_o, gen_pos_o     - generator launch and square
//            gen_active_i .. gen_valid_i- generator candidate stream
//            mv_valid_o, mv_ready_i,
//            mv_from_o, mv_to_o,
//            mv_capture_o               - move output handshake
//            busy_o, done_o, no_king_o,
//            move_count_o               - run status
// Revision : 1.0 - initial release
// ============================================================================
module king_move_scheduler #(
   parameter int         PIECE_W     = 4,
   parameter logic [2:0] KING_TYPE   = 3'd6,
   parameter int         GEN_TIMEOUT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               side_i,
   output logic [5:0]         bd_addr_o,
   input  logic [PIECE_W-1:0] bd_piece_i,
   output logic               gen_start_o,
   output logic [5:0]         gen_pos_o,
   input  logic               gen_active_i,
   input  logic [2:0]         gen_number_i,
   input  logic [2:0]         gen_row_i,
   input  logic [2:0]         gen_col_i,
   input  logic               gen_valid_i,
   output logic               mv_valid_o,
   input  logic               mv_ready_i,
   output logic [5:0]         mv_from_o,
   output logic [5:0]         mv_to_o,
   output logic               mv_capture_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               no_king_o,
   output logic [3:0]         move_count_o
);

   localparam int                  c_WAIT_W     = $clog2(GEN_TIMEOUT + 1) + 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(GEN_TIMEOUT);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_SCAN    = 3'd1;
   localparam logic [2:0] c_LAUNCH  = 3'd2;
   localparam logic [2:0] c_COLLECT = 3'd3;
   localparam logic [2:0] c_DRAIN   = 3'd4;
   localparam logic [2:0] c_DONE    = 3'd5;

   logic [2:0]          state_q, state_d;
   logic                side_q;
   logic [5:0]          scan_idx_q;
   logic [5:0]          king_sq_q;
   logic [c_WAIT_W-1:0] wait_q;
   logic                seen_q;
   logic [2:0]          drain_idx_q;
   logic                no_king_q;
   logic [3:0]          move_count_q;
   logic                done_q;

   logic [5:0]          tgt_q [8];
   logic [7:0]          keep_q;
   logic [7:0]          cap_q;

   // Board square decode (colour in the MSB, type in the low three bits)
   logic       w_piece_col;
   logic [2:0] w_piece_type;
   logic       w_piece_empty;
   logic       w_piece_enemy;
   assign w_piece_col   = bd_piece_i[PIECE_W-1];
   assign w_piece_type  = bd_piece_i[2:0];
   assign w_piece_empty = (w_piece_type == 3'd0);
   assign w_piece_enemy = (w_piece_col != side_q);

   logic w_start_ok, w_king_hit, w_scan_end, w_slot_we, w_last_slot;
   logic w_timeout, w_cur_keep, w_drain_step, w_drain_end, w_mv_fire;
   logic w_keep, w_cap;

   assign w_start_ok  = start_i && ((state_q == c_IDLE) || (state_q == c_DONE));
   assign w_king_hit  = (state_q == c_SCAN) && !w_piece_enemy &&
                        (w_piece_type == KING_TYPE);
   assign w_scan_end  = (scan_idx_q == 6'd63);
   assign w_slot_we   = (state_q == c_COLLECT) && gen_active_i;
   assign w_last_slot = w_slot_we && (gen_number_i == 3'd7);
   // Once the generator has shown any activity the burst is trusted to finish.
   assign w_timeout   = (state_q == c_COLLECT) && !seen_q && !gen_active_i &&
                        (wait_q >= c_WAIT_LIMIT);
   assign w_cur_keep  = keep_q[drain_idx_q];
   // Dropped slots advance immediately; kept slots wait for the consumer.
   assign w_drain_step = (state_q == c_DRAIN) && (!w_cur_keep || mv_ready_i);
   assign w_drain_end  = w_drain_step && (drain_idx_q == 3'd7);
   assign w_mv_fire    = mv_valid_o && mv_ready_i;

   assign w_keep = gen_valid_i && (w_piece_empty || w_piece_enemy);
   assign w_cap  = gen_valid_i && !w_piece_empty && w_piece_enemy;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:    if (w_start_ok) state_d = c_SCAN;
         c_SCAN: begin
            if (w_king_hit)      state_d = c_LAUNCH;
            else if (w_scan_end) state_d = c_DONE;
         end
         c_LAUNCH:  state_d = c_COLLECT;
         c_COLLECT: begin
            if (w_timeout)        state_d = c_DONE;
            else if (w_last_slot) state_d = c_DRAIN;
         end
         c_DRAIN:   if (w_drain_end) state_d = c_DONE;
         c_DONE:    if (w_start_ok) state_d = c_SCAN;
         default:   state_d = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      bd_addr_o    = 6'd0;
      gen_start_o  = 1'b0;
      gen_pos_o    = 6'd0;
      mv_valid_o   = 1'b0;
      mv_from_o    = 6'd0;
      mv_to_o      = 6'd0;
      mv_capture_o = 1'b0;
      busy_o       = 1'b1;
      case (state_q)
         c_IDLE:   busy_o = 1'b0;
         c_DONE:   busy_o = 1'b0;
         c_SCAN:   bd_addr_o = scan_idx_q;
         c_LAUNCH: begin
            gen_start_o = 1'b1;
            gen_pos_o   = king_sq_q;
         end
         c_COLLECT: begin
            gen_start_o = 1'b1;
            gen_pos_o   = king_sq_q;
            // Look up the candidate square so it can be filtered on arrival.
            bd_addr_o   = {gen_row_i, gen_col_i};
         end
         c_DRAIN: begin
            if (w_cur_keep) begin
               mv_valid_o   = 1'b1;
               mv_from_o    = king_sq_q;
               mv_to_o      = tgt_q[drain_idx_q];
               mv_capture_o = cap_q[drain_idx_q];
            end
         end
         default: busy_o = 1'b0;
      endcase
   end

   assign done_o       = done_q;
   assign no_king_o    = no_king_q;
   assign move_count_o = move_count_q;

   // ------------------------------------------------------------------
   // Control datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         side_q       <= 1'b0;
         scan_idx_q   <= 6'd0;
         king_sq_q    <= 6'd0;
         wait_q       <= '0;
         seen_q       <= 1'b0;
         drain_idx_q  <= 3'd0;
         no_king_q    <= 1'b0;
         move_count_q <= 4'd0;
         done_q       <= 1'b0;
      end else begin
         // done marks the first cycle spent in DONE, whatever the cause.
         done_q <= (state_d == c_DONE) && (state_q != c_DONE);

         if (w_start_ok) begin
            side_q       <= side_i;
            scan_idx_q   <= 6'd0;
            no_king_q    <= 1'b0;
            move_count_q <= 4'd0;
         end

         if (state_q == c_SCAN) begin
            if (w_king_hit) begin
               king_sq_q <= scan_idx_q;
            end else if (w_scan_end) begin
               no_king_q <= 1'b1;
            end else begin
               scan_idx_q <= scan_idx_q + 6'd1;
            end
         end

         if (state_q == c_LAUNCH) begin
            wait_q <= c_WAIT_W'(1);
            seen_q <= 1'b0;
         end

         if (state_q == c_COLLECT) begin
            if (gen_active_i) begin
               seen_q <= 1'b1;
            end else if (!seen_q && !w_timeout) begin
               wait_q <= wait_q + c_WAIT_W'(1);
            end
         end

         if (w_timeout) begin
            no_king_q <= 1'b1;
         end

         if (w_last_slot) begin
            drain_idx_q <= 3'd0;
         end else if (w_drain_step) begin
            drain_idx_q <= drain_idx_q + 3'd1;
         end

         if (w_mv_fire) begin
            move_count_q <= move_count_q + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Candidate buffer, indexed by the generator's candidate number
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keep_q <= 8'd0;
         cap_q  <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            tgt_q[i] <= 6'd0;
         end
      end else if (w_start_ok) begin
         keep_q <= 8'd0;
         cap_q  <= 8'd0;
      end else if (w_slot_we) begin
         tgt_q[gen_number_i]  <= {gen_row_i, gen_col_i};
         keep_q[gen_number_i] <= w_keep;
         cap_q[gen_number_i]  <= w_cap;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_king_move_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_king_move_scheduler
// Purpose  : Self-checking bench for king_move_scheduler. Provides a board
//            memory, a behavioural king-move generator and a table of runs
//            with hand-computed move lists, plus reset and timeout sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_king_move_scheduler;

   localparam int GEN_TIMEOUT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       side = 1'b0;
   logic [5:0] bd_addr;
   logic [3:0] bd_piece;
   logic       gen_start;
   logic [5:0] gen_pos;
   logic       gen_active;
   logic [2:0] gen_number;
   logic [2:0] gen_row;
   logic [2:0] gen_col;
   logic       gen_valid;
   logic       mv_valid;
   logic       mv_ready = 1'b0;
   logic [5:0] mv_from;
   logic [5:0] mv_to;
   logic       mv_capture;
   logic       busy;
   logic       done;
   logic       no_king;
   logic [3:0] move_count;

   king_move_scheduler #(
      .PIECE_W(4), .KING_TYPE(3'd6), .GEN_TIMEOUT(GEN_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .side_i(side),
      .bd_addr_o(bd_addr), .bd_piece_i(bd_piece),
      .gen_start_o(gen_start), .gen_pos_o(gen_pos),
      .gen_active_i(gen_active), .gen_number_i(gen_number),
      .gen_row_i(gen_row), .gen_col_i(gen_col), .gen_valid_i(gen_valid),
      .mv_valid_o(mv_valid), .mv_ready_i(mv_ready),
      .mv_from_o(mv_from), .mv_to_o(mv_to), .mv_capture_o(mv_capture),
      .busy_o(busy), .done_o(done), .no_king_o(no_king),
      .move_count_o(move_count)
   );

   always #5 clk = ~clk;

   logic [3:0] board [64];
   assign bd_piece = board[bd_addr];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural king-move generator ----------------
   bit   gen_en = 1'b1;
   int   gcnt = -1;
   logic gprev = 1'b0;
   int   kr, kc, gr, gc;
   int   dr [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
   int   dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

   initial begin
      gen_active = 1'b0; gen_number = 3'd0; gen_row = 3'd0;
      gen_col = 3'd0; gen_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            gcnt = -1;
            gen_active = 1'b0;
         end else if (gcnt >= 0 && gcnt < 8) begin
            gr = kr + dr[gcnt];
            gc = kc + dc[gcnt];
            gen_number = gcnt[2:0];
            gen_row    = gr[2:0];
            gen_col    = gc[2:0];
            gen_valid  = (gr >= 0 && gr < 8 && gc >= 0 && gc < 8);
            gen_active = 1'b1;
            gcnt++;
         end else begin
            gen_active = 1'b0;
            gcnt = -1;
         end
         if (rst_n && gen_en && gen_start && !gprev && gcnt < 0) begin
            gcnt = 0;
            kr = int'(gen_pos[5:3]);
            kc = int'(gen_pos[2:0]);
         end
         gprev = gen_start;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      int         ksq;  logic [3:0] kcode;
      int         s1;   logic [3:0] c1;
      int         s2;   logic [3:0] c2;
      int         s3;   logic [3:0] c3;
      logic       sd;
      logic [3:0] rdy;
      int         n;
      logic [47:0] to;
      logic [7:0] cap;
      logic       nk;
      int         bsy;
   } vec_t;

   vec_t vt [7];

   function automatic logic [47:0] tl(int a0, int a1, int a2, int a3,
                                      int a4, int a5, int a6, int a7);
      logic [47:0] r;
      r[5:0]   = a0[5:0]; r[11:6]  = a1[5:0]; r[17:12] = a2[5:0];
      r[23:18] = a3[5:0]; r[29:24] = a4[5:0]; r[35:30] = a5[5:0];
      r[41:36] = a6[5:0]; r[47:42] = a7[5:0];
      return r;
   endfunction

   function automatic vec_t mk(int ksq, logic [3:0] kcode, int s1, logic [3:0] c1,
                               int s2, logic [3:0] c2, int s3, logic [3:0] c3,
                               logic sd, logic [3:0] rdy, int n, logic [47:0] to,
                               logic [7:0] cap, logic nk, int bsy);
      vec_t v;
      v.ksq = ksq; v.kcode = kcode; v.s1 = s1; v.c1 = c1; v.s2 = s2; v.c2 = c2;
      v.s3 = s3; v.c3 = c3; v.sd = sd; v.rdy = rdy; v.n = n; v.to = to;
      v.cap = cap; v.nk = nk; v.bsy = bsy;
      return v;
   endfunction

   task automatic clear_board();
      for (int i = 0; i < 64; i++) board[i] = 4'h0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int  k = 0, cyc = 0, dones = 0, busy_n = 0, hs = 0;
      bit  fin = 1'b0;
      logic [47:0] tov;
      int  exp_to;
      string tag;
      tag = $sformatf("v%0d", id);
      clear_board();
      if (v.ksq >= 0) board[v.ksq] = v.kcode;
      if (v.s1 >= 0)  board[v.s1]  = v.c1;
      if (v.s2 >= 0)  board[v.s2]  = v.c2;
      if (v.s3 >= 0)  board[v.s3]  = v.c3;
      tov = v.to;
      @(negedge clk);
      start = 1'b1; side = v.sd; mv_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 400) begin
         mv_ready = v.rdy[hs % 4];
         if (busy) busy_n++;
         if (mv_valid) begin
            hs++;
            if (k < v.n) begin
               exp_to = int'(tov[k*6 +: 6]);
               chk({tag, "_from"}, mv_from, v.ksq);
               chk({tag, "_to"}, mv_to, exp_to);
               chk({tag, "_cap"}, mv_capture, v.cap[k]);
            end else begin
               n_vec++; n_err++;
               $display("FAIL %s_extra_move: got move to %0d, expected none", tag, mv_to);
            end
            if (mv_ready) k++;
         end
         if (done) begin
            dones++;
            fin = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_finished"}, fin, 1);
      repeat (2) begin
         if (done) dones++;
         if (mv_valid) k++;
         @(negedge clk);
      end
      mv_ready = 1'b0;
      chk({tag, "_moves"}, k, v.n);
      chk({tag, "_move_count"}, move_count, v.n);
      chk({tag, "_no_king"}, no_king, v.nk);
      chk({tag, "_done_pulses"}, dones, 1);
      if (v.bsy >= 0) chk({tag, "_busy_cycles"}, busy_n, v.bsy);
   endtask

   initial begin
      int t, lcyc, dcyc, bad;
      vt[0] = mk(18, 4'h6, -1, 4'h0, -1, 4'h0, -1, 4'h0, 1'b0, 4'hF, 8,
                 tl(26, 27, 19, 11, 10, 9, 17, 25), 8'h00, 1'b0, 36);
      vt[1] = mk(0, 4'h6, -1, 4'h0, -1, 4'h0, -1, 4'h0, 1'b0, 4'hF, 3,
                 tl(8, 9, 1, 0, 0, 0, 0, 0), 8'h00, 1'b0, 18);
      vt[2] = mk(60, 4'h6, 59, 4'h1, 51, 4'hC, -1, 4'h0, 1'b0, 4'hF, 4,
                 tl(61, 53, 52, 51, 0, 0, 0, 0), 8'h08, 1'b0, -1);
      vt[3] = mk(-1, 4'h0, 10, 4'hE, 40, 4'hC, -1, 4'h0, 1'b0, 4'hF, 0,
                 48'd0, 8'h00, 1'b1, 64);
      vt[4] = mk(49, 4'h6, -1, 4'h0, -1, 4'h0, -1, 4'h0, 1'b0, 4'b1001, 8,
                 tl(57, 58, 50, 42, 41, 40, 48, 56), 8'h00, 1'b0, -1);
      vt[5] = mk(36, 4'hE, 44, 4'h2, 35, 4'h9, 5, 4'h6, 1'b1, 4'hF, 7,
                 tl(44, 45, 37, 29, 28, 27, 43, 0), 8'h01, 1'b0, -1);
      vt[6] = mk(7, 4'h6, 63, 4'h6, -1, 4'h0, -1, 4'h0, 1'b0, 4'hF, 3,
                 tl(15, 6, 14, 0, 0, 0, 0, 0), 8'h00, 1'b0, -1);

      clear_board();
      repeat (3) @(negedge clk);
      chk("reset_addr_outputs", int'({bd_addr, gen_pos, mv_from, mv_to}), 0);
      chk("reset_flag_outputs",
          int'({gen_start, mv_valid, mv_capture, busy, done, no_king, move_count}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vt[i], i);

      // Reset in the middle of a stalled handshake
      clear_board();
      board[18] = 4'h6;
      start = 1'b1; side = 1'b0; mv_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!mv_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("rst_reach_drain", mv_valid, 1);
      chk("rst_first_to", mv_to, 26);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst_start_ignored_busy", busy, 1);
      chk("rst_stall_hold_to", mv_to, 26);
      chk("rst_stall_hold_valid", mv_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_addr", int'({bd_addr, gen_pos, mv_from, mv_to}), 0);
      chk("rst_async_flags",
          int'({gen_start, mv_valid, mv_capture, busy, done, no_king, move_count}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vt[0], 10);

      // Generator never answers
      gen_en = 1'b0;
      clear_board();
      board[18] = 4'h6;
      start = 1'b1; side = 1'b0;
      @(negedge clk);
      start = 1'b0;
      t = 0; lcyc = -1; dcyc = -1; bad = 0;
      while (dcyc < 0 && t < 200) begin
         if (gen_start && lcyc < 0) lcyc = t;
         if (done) dcyc = t;
         if (mv_valid) bad++;
         @(negedge clk);
         t++;
      end
      chk("timeout_delay", dcyc - lcyc, GEN_TIMEOUT + 1);
      chk("timeout_no_king", no_king, 1);
      chk("timeout_move_count", move_count, 0);
      chk("timeout_no_moves", bad, 0);
      gen_en = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/king_move_scheduler.md
Name: king_move_scheduler

Overview:
- Sequences one `nextkingpositions2` generator instance to produce the pseudo-legal king moves for the side to move.
- Scans the board through a single read port to locate that side's king, then launches the generator on the king's square.
- Collects the generator's 8 candidate targets in one burst and filters them against board occupancy.
- Drains the surviving moves to the downstream move consumer over a valid/ready handshake.

Parameters:
- PIECE_W, 4, width of a board square code: bit[3] = colour (0 white, 1 black), bits[2:0] = piece type, type 0 = empty.
- KING_TYPE, 3'd6, piece-type code of the king.
- GEN_TIMEOUT, 4, maximum cycles after launch to wait for gen_active before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to generate king moves; honoured only in IDLE or DONE.
- side  in  1  colour to move; sampled when start is accepted.
- bd_addr  out  6  board read address {row,col}.
- bd_piece  in  PIECE_W  square code at bd_addr; combinational, same cycle.
- gen_start  out  1  start input of the generator.
- gen_pos  out  6  square given to the generator.
- gen_active  in  1  generator is producing candidates.
- gen_number  in  3  candidate index 0..7.
- gen_row  in  3  candidate target row.
- gen_col  in  3  candidate target column.
- gen_valid  in  1  candidate lies on the board.
- mv_valid  out  1  move available.
- mv_ready  in  1  consumer accepts the move.
- mv_from  out  6  king square.
- mv_to  out  6  target square.
- mv_capture  out  1  target holds an opposing piece.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the sequence ends.
- no_king  out  1  sticky: the last run found no king or the generator timed out.
- move_count  out  4  number of moves emitted in the last run (0..8).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - All outputs 0; bd_addr = 0, gen_pos = 0, move_count = 0.
  - Candidate buffer cleared.
- Start acceptance:
  - In IDLE or DONE, start=1 latches side, clears no_king and move_count, and enters SCAN with scan index 0.
  - In any other state start is ignored.
- SCAN:
  - bd_addr = scan index, one square per cycle.
  - If bd_piece == {side, KING_TYPE}: latch king_sq = scan index and go to LAUNCH. The first match in index order wins.
  - If index 63 does not match: set no_king, pulse done, go to DONE.
  - Worst-case scan is 64 cycles.
- LAUNCH:
  - gen_pos = king_sq and gen_start = 1.
  - Both are held through COLLECT. gen_start is 0 in all other states.
  - Next state is COLLECT; a wait counter starts.
- COLLECT:
  - bd_addr = {gen_row, gen_col}.
  - On every cycle with gen_active=1, slot[gen_number] is written as follows:
    - target = {gen_row, gen_col}.
    - keep = gen_valid && (bd_piece type == 0 || bd_piece colour != side).
    - cap = gen_valid && bd_piece type != 0 && bd_piece colour != side.
  - After slot 7 is written, go to DRAIN with drain index 0.
  - If gen_active has not been seen within GEN_TIMEOUT cycles of LAUNCH: set no_king, pulse done, go to DONE.
- DRAIN:
  - Advance the drain index past slots with keep=0, one slot per cycle.
  - On a kept slot, drive mv_valid=1 with mv_from = king_sq, mv_to = slot target, mv_capture = slot cap.
  - mv_* stay stable while mv_valid && !mv_ready.
  - On mv_valid && mv_ready: move_count increments and the index advances.
  - When the index passes 7: mv_valid=0, pulse done, go to DONE. move_count never exceeds 8.
  - mv_valid is never asserted outside DRAIN.
- DONE:
  - busy=0; move_count and no_king hold their values.
  - start is accepted as in IDLE.
- Reset mid-run: everything returns to the reset values immediately, including mid-handshake. Any pending move is lost.

Test Plan:
- White king alone on square 18 (row 2, col 2), mv_ready=1:
  - 8 moves emitted, targets 26, 27, 19, 11, 10, 9, 17, 25 in that order.
  - All have mv_capture=0; move_count=8; done pulses once.
- White king on square 0 (corner):
  - Exactly 3 moves, targets 8, 9, 1; move_count=3.
- White king on square 60 (row 7, col 4), own pawn on 59, black rook on 51:
  - 4 moves, targets 61, 53, 52, 51; only target 51 has mv_capture=1.
- Board with only black pieces, side=0:
  - SCAN covers all 64 squares, then no_king=1, done pulses, mv_valid never rises.
- King on square 49 (row 6, col 1), mv_ready toggled 1-0-0-1:
  - mv_from, mv_to and mv_capture are held while stalled.
  - No move is dropped or duplicated; move_count=8.
- Two cases checked separately:
  - Pulse rst_n low during DRAIN: all outputs drop to 0 asynchronously, and a following start runs a full sequence again.
  - Hold gen_active=0 after LAUNCH: no_king=1 after GEN_TIMEOUT cycles.
